// File: rtl/dds_wave_gen.sv
// ---------------------------------------------------------------------------
// dds_wave_gen
//
// Direct digital synthesis waveform generator. A phase accumulator advances
// by the frequency control word on every taken sample; the phase (plus a
// per-sample offset) indexes a quarter-wave symmetric sine ROM that is built
// at elaboration. Sine, cosine, square and sawtooth shapes are produced as
// registered offset-binary samples with a valid strobe, three cycles after
// the sample is taken.
//
// Optional feature macro: DDS_PHASE_DITHER_EN
//   When defined, a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed
//   16'hACE1) adds pseudo-random bits below the table index to spread phase
//   truncation spurs. When undefined the generator is fully deterministic.
//
// Parameters:
//   PHASE_W  accumulator / tuning word width
//   ADDR_W   full-wave table index width (ROM holds 2^(ADDR_W-2)+1 entries)
//   OUT_W    output sample width, offset binary
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          take one sample this cycle and advance the accumulator
//   clr         synchronous clear of accumulator and pipeline, wins over en
//   fcw         frequency control word added per sample
//   phase_off   phase offset added before lookup
//   mode        0 sine, 1 cosine, 2 square, 3 sawtooth
//   sample_out  generated sample (holds between valid samples)
//   out_valid   sample_out carries a new sample this cycle
// ---------------------------------------------------------------------------
module dds_wave_gen #(
    parameter int PHASE_W = 24,
    parameter int ADDR_W  = 8,
    parameter int OUT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [PHASE_W-1:0] fcw,
    input  logic [PHASE_W-1:0] phase_off,
    input  logic [1:0]         mode,
    output logic [OUT_W-1:0]   sample_out,
    output logic               out_valid
);

    localparam int  J_W   = ADDR_W - 2;
    localparam int  IDX_W = ADDR_W - 1;
    localparam int  Q     = 2 ** J_W;
    localparam real PI    = 3.14159265358979323846;

    // Midscale equals the sine amplitude; full scale is twice that.
    localparam logic [OUT_W-1:0]   MID  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]   FULL = {{(OUT_W-1){1'b1}}, 1'b0};
    localparam logic [PHASE_W-1:0] QTR  = {2'b01, {(PHASE_W-2){1'b0}}};
    localparam logic [IDX_W-1:0]   QIDX = {1'b1, {J_W{1'b0}}};

    // Round a non-negative real to nearest, ties away from zero.
    function automatic logic [OUT_W-1:0] round_pos(input real v);
        return OUT_W'($rtoi(v + 0.5));
    endfunction

    // Quarter-wave table entry j: round(A*sin(2*pi*j/2^ADDR_W)).
    function automatic logic [OUT_W-1:0] rom_entry(input int j);
        real amp;
        real ang;
        amp = (2.0 ** (OUT_W - 1)) - 1.0;
        ang = (2.0 * PI * j) / (2.0 ** ADDR_W);
        return round_pos(amp * $sin(ang));
    endfunction

    // Map quadrant and table magnitude to the selected output shape.
    function automatic logic [OUT_W-1:0] shape(input logic [1:0]       m,
                                               input logic [1:0]       quad,
                                               input logic [OUT_W-1:0] mag,
                                               input logic [OUT_W-1:0] saw);
        logic signed [OUT_W:0] bip;
        logic signed [OUT_W:0] sum;
        bip = quad[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        sum = $signed({1'b0, MID}) + bip;
        case (m)
            2'd2:    return quad[1] ? '0 : FULL;
            2'd3:    return saw;
            default: return sum[OUT_W-1:0];
        endcase
    endfunction

    logic [OUT_W-1:0] rom [Q+1];

    for (genvar g = 0; g <= Q; g++) begin : g_rom
        assign rom[g] = rom_entry(g);
    end

    logic               take;
    logic [PHASE_W-1:0] acc;

    logic [PHASE_W-1:0] p_p0;
    logic [PHASE_W-1:0] off_p0;
    logic [1:0]         mode_p0;
    logic               vld_p0;

    logic [PHASE_W-1:0] pe;
    logic               unused_pe;

    logic [1:0]         quad_p1;
    logic [J_W-1:0]     j_p1;
    logic [1:0]         mode_p1;
    logic [OUT_W-1:0]   saw_p1;
    logic               vld_p1;

    logic [IDX_W-1:0]   rom_idx;

    logic [OUT_W-1:0]   mag_p2;
    logic [1:0]         quad_p2;
    logic [1:0]         mode_p2;
    logic [OUT_W-1:0]   saw_p2;
    logic               vld_p2;

    assign take = en && !clr;

`ifdef DDS_PHASE_DITHER_EN
    localparam int DITH_W = ((PHASE_W - ADDR_W) < 16) ? (PHASE_W - ADDR_W) : 16;

    logic [15:0]        lfsr;
    logic [PHASE_W-1:0] dith_next;
    logic [PHASE_W-1:0] dith_p0;

    always_comb begin
        dith_next = '0;
        for (int i = 0; i < DITH_W; i++) begin
            dith_next[i] = lfsr[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr    <= 16'hACE1;
            dith_p0 <= '0;
        end else if (clr) begin
            lfsr    <= 16'hACE1;
        end else if (take) begin
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            dith_p0 <= dith_next;
        end
    end
`endif

    // ---- stage 0: capture phase and per-sample controls, advance accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            p_p0    <= '0;
            off_p0  <= '0;
            mode_p0 <= '0;
            vld_p0  <= 1'b0;
        end else if (clr) begin
            acc     <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0  <= en;
            if (en) begin
                acc     <= acc + fcw;
                p_p0    <= acc;
                off_p0  <= phase_off;
                mode_p0 <= mode;
            end
        end
    end

    always_comb begin
        pe = p_p0 + off_p0 + ((mode_p0 == 2'd1) ? QTR : '0);
`ifdef DDS_PHASE_DITHER_EN
        pe = pe + dith_p0;
`endif
    end

    // Bits of pe below the table index are only needed for the carry.
    assign unused_pe = &{1'b0, pe};

    // ---- stage 1: effective phase split into quadrant and table index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quad_p1 <= '0;
            j_p1    <= '0;
            mode_p1 <= '0;
            saw_p1  <= '0;
            vld_p1  <= 1'b0;
        end else begin
            quad_p1 <= pe[PHASE_W-1 -: 2];
            j_p1    <= pe[PHASE_W-3 -: J_W];
            mode_p1 <= mode_p0;
            saw_p1  <= pe[PHASE_W-1 -: OUT_W];
            vld_p1  <= vld_p0 && !clr;
        end
    end

    // Odd quadrants run the quarter table backwards.
    always_comb begin
        if (quad_p1[0]) begin
            rom_idx = QIDX - {1'b0, j_p1};
        end else begin
            rom_idx = {1'b0, j_p1};
        end
    end

    // ---- stage 2: registered ROM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_p2  <= '0;
            quad_p2 <= '0;
            mode_p2 <= '0;
            saw_p2  <= '0;
            vld_p2  <= 1'b0;
        end else begin
            mag_p2  <= rom[rom_idx];
            quad_p2 <= quad_p1;
            mode_p2 <= mode_p1;
            saw_p2  <= saw_p1;
            vld_p2  <= vld_p1 && !clr;
        end
    end

    // ---- stage 3: output shaping; sample_out holds across bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_out <= MID;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= vld_p2 && !clr;
            if (vld_p2 && !clr) begin
                sample_out <= shape(mode_p2, quad_p2, mag_p2, saw_p2);
            end
        end
    end

endmodule
